axis_rr_arbiter: RTL and testbench

Packet-level round-robin arbiter that merges NS AXI4-Stream sources onto one AXI4-Stream sink. Typical use is sharing a single downstream stream consumer (DMA, framer, DSI packet engine) between several producers. A grant is held from the first beat of a packet through the beat with TLAST=1, so packets are never interleaved.

---
 rtl/axis_rr_arbiter_pkg.sv | 52 +++++
 rtl/axis_rr_arbiter_pick.sv | 49 ++++
 rtl/axis_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axis_arb_pkg
// Shared types and helpers for the AXI4-Stream round-robin arbiter.
//   state_t  : arbiter FSM states (ST_IDLE, ST_BUSY)
//   pick_t   : result of a round-robin scan (valid flag + winning index)
//   ptr_w()  : width of the last-served pointer for a given input count
//   rr_pick(): rotate-priority scan starting one past the last-served input
// ---------------------------------------------------------------------------
package axis_arb_pkg;

    localparam int NS_MAX    = 16;
    localparam int PTR_W_MAX = $clog2(NS_MAX);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [PTR_W_MAX-1:0] idx;
    } pick_t;

    // Pointer width, clog2(ns), never narrower than one bit.
    function automatic int ptr_w(input int ns);
        return (ns < 2) ? 1 : $clog2(ns);
    endfunction

    // Scan req starting at (last+1) mod ns and wrapping; first hit wins.
    // Vectors are sized for the largest supported arbiter; only the low
    // ns bits of req are considered.
    function automatic pick_t rr_pick(input logic [NS_MAX-1:0]    req,
                                      input int unsigned          ns,
                                      input logic [PTR_W_MAX-1:0] last);
        pick_t       r;
        int unsigned cand;
        r = '0;
        for (int unsigned k = 1; k <= NS_MAX; k++) begin
            // last < ns and k <= ns, so one conditional subtract is a modulo
            cand = 32'(last) + k;
            if (cand >= ns) begin
                cand = cand - ns;
            end
            if ((k <= ns) && !r.valid && req[PTR_W_MAX'(cand)]) begin
                r.valid = 1'b1;
                r.idx   = PTR_W_MAX'(cand);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_pick_core
// Combinational rotate-priority encoder plus the last-served pointer.
// The pointer resets to NS-1 so input 0 has top priority after reset, and
// moves to the winner whenever i_update is asserted with a valid pick.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_req        : per-input request vector
//   i_update     : commit the current pick as the last-served input
//   o_valid      : at least one request present
//   o_idx        : winning input index
// ---------------------------------------------------------------------------
import axis_arb_pkg::*;

module rr_pick_core #(
    parameter  int NS = 4,
    localparam int PW = ptr_w(NS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [NS-1:0] i_req,
    input  logic          i_update,
    output logic          o_valid,
    output logic [PW-1:0] o_idx
);

    logic [PW-1:0]        r_last;
    logic [NS_MAX-1:0]    w_req_ext;
    logic [PTR_W_MAX-1:0] w_last_ext;
    pick_t                w_pick;

    always_comb begin
        w_req_ext          = '0;
        w_req_ext[NS-1:0]  = i_req;
        w_last_ext         = PTR_W_MAX'(r_last);
        w_pick             = rr_pick(w_req_ext, NS, w_last_ext);
    end

    assign o_valid = w_pick.valid;
    assign o_idx   = PW'(w_pick.idx);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= PW'(NS - 1);
        end else if (i_update && w_pick.valid) begin
            r_last <= o_idx;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter
// Packet-level round-robin merge of NS AXI4-Stream sources onto one sink.
// A grant is taken in IDLE and held until the granted source completes a
// TLAST beat, so packets never interleave. One dead (IDLE) cycle separates
// consecutive packets; no data is buffered.
//
// Handshake: a beat moves on a rising edge when the granted S_TVALID and
// M_TREADY are both high. While BUSY the granted source sees M_TREADY
// directly on its S_TREADY and the sink sees that source's TVALID/sideband
// combinationally; every other S_TREADY is held low. In IDLE all S_TREADY,
// M_TVALID and M_T* outputs are zero.
//
// Ports:
//   ACLK, ARESET         clock, synchronous active-high reset
//   S_T*                 packed per-source AXI4-Stream inputs (slice k)
//   M_T*                 merged AXI4-Stream output
//   GRANT                one-hot current grant, zero when idle
//   BUSY                 packet in flight
//   o_dbg_state          FSM state (0 = IDLE, 1 = BUSY)
// ---------------------------------------------------------------------------
import axis_arb_pkg::*;

module axis_rr_arbiter #(
    parameter int NS = 4,
    parameter int N  = 4,
    parameter int I  = 1,
    parameter int D  = 1,
    parameter int U  = 1
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [NS-1:0]     S_TVALID,
    output logic [NS-1:0]     S_TREADY,
    input  logic [NS*8*N-1:0] S_TDATA,
    input  logic [NS*N-1:0]   S_TSTRB,
    input  logic [NS*N-1:0]   S_TKEEP,
    input  logic [NS-1:0]     S_TLAST,
    input  logic [NS*I-1:0]   S_TID,
    input  logic [NS*D-1:0]   S_TDEST,
    input  logic [NS*U-1:0]   S_TUSER,
    output logic              M_TVALID,
    input  logic              M_TREADY,
    output logic [8*N-1:0]    M_TDATA,
    output logic [N-1:0]      M_TSTRB,
    output logic [N-1:0]      M_TKEEP,
    output logic              M_TLAST,
    output logic [I-1:0]      M_TID,
    output logic [D-1:0]      M_TDEST,
    output logic [U-1:0]      M_TUSER,
    output logic [NS-1:0]     GRANT,
    output logic              BUSY,
    output logic              o_dbg_state
);

    localparam int PW = ptr_w(NS);

    state_t        r_state;
    logic [NS-1:0] r_grant;
    logic          r_busy;

    logic          w_take;
    logic          w_pick_valid;
    logic [PW-1:0] w_pick_idx;
    logic          w_beat;

    // The pointer only advances when IDLE actually commits a grant.
    assign w_take = (r_state == ST_IDLE);

    rr_pick_core #(
        .NS (NS)
    ) u_pick (
        .i_clk    (ACLK),
        .i_rst    (ARESET),
        .i_req    (S_TVALID),
        .i_update (w_take),
        .o_valid  (w_pick_valid),
        .o_idx    (w_pick_idx)
    );

    assign w_beat = M_TVALID & M_TREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= ST_BUSY;
                        r_grant <= NS'(1) << w_pick_idx;
                        r_busy  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_beat && M_TLAST) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // One-hot AND-OR mux: a zero grant in IDLE forces every output low.
    always_comb begin
        M_TDATA = '0;
        M_TSTRB = '0;
        M_TKEEP = '0;
        M_TID   = '0;
        M_TDEST = '0;
        M_TUSER = '0;
        for (int k = 0; k < NS; k++) begin
            if (r_grant[k]) begin
                M_TDATA = M_TDATA | S_TDATA[k*8*N +: 8*N];
                M_TSTRB = M_TSTRB | S_TSTRB[k*N +: N];
                M_TKEEP = M_TKEEP | S_TKEEP[k*N +: N];
                M_TID   = M_TID   | S_TID[k*I +: I];
                M_TDEST = M_TDEST | S_TDEST[k*D +: D];
                M_TUSER = M_TUSER | S_TUSER[k*U +: U];
            end
        end
    end

    assign M_TVALID    = |(r_grant & S_TVALID);
    assign M_TLAST     = |(r_grant & S_TLAST);
    assign S_TREADY    = r_grant & {NS{M_TREADY}};
    assign GRANT       = r_grant;
    assign BUSY        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_rr_arbiter
// Directed bench for the round-robin AXI4-Stream arbiter (NS=4, N=4).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit
// later, and a negedge monitor compares every M-side beat with exp_q.
// ---------------------------------------------------------------------------
module tb_axis_rr_arbiter;

    localparam int NS = 4;
    localparam int N  = 4;
    localparam int I  = 1;
    localparam int D  = 1;
    localparam int U  = 1;
    localparam int W  = 34;   // {tid, last, data}

    // ---------------- clock / reset ----------------
    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    logic [NS-1:0]     S_TVALID;
    logic [NS-1:0]     S_TREADY;
    logic [NS*8*N-1:0] S_TDATA;
    logic [NS*N-1:0]   S_TSTRB;
    logic [NS*N-1:0]   S_TKEEP;
    logic [NS-1:0]     S_TLAST;
    logic [NS*I-1:0]   S_TID;
    logic [NS*D-1:0]   S_TDEST;
    logic [NS*U-1:0]   S_TUSER;
    logic              M_TVALID;
    logic              M_TREADY;
    logic [8*N-1:0]    M_TDATA;
    logic [N-1:0]      M_TSTRB;
    logic [N-1:0]      M_TKEEP;
    logic              M_TLAST;
    logic [I-1:0]      M_TID;
    logic [D-1:0]      M_TDEST;
    logic [U-1:0]      M_TUSER;
    logic [NS-1:0]     GRANT;
    logic              BUSY;
    logic              o_dbg_state;

    axis_rr_arbiter #(.NS(NS), .N(N), .I(I), .D(D), .U(U)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .S_TVALID    (S_TVALID),
        .S_TREADY    (S_TREADY),
        .S_TDATA     (S_TDATA),
        .S_TSTRB     (S_TSTRB),
        .S_TKEEP     (S_TKEEP),
        .S_TLAST     (S_TLAST),
        .S_TID       (S_TID),
        .S_TDEST     (S_TDEST),
        .S_TUSER     (S_TUSER),
        .M_TVALID    (M_TVALID),
        .M_TREADY    (M_TREADY),
        .M_TDATA     (M_TDATA),
        .M_TSTRB     (M_TSTRB),
        .M_TKEEP     (M_TKEEP),
        .M_TLAST     (M_TLAST),
        .M_TID       (M_TID),
        .M_TDEST     (M_TDEST),
        .M_TUSER     (M_TUSER),
        .GRANT       (GRANT),
        .BUSY        (BUSY),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int extra_beats = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic tid, input logic last, input logic [31:0] data);
        exp_q.push_back({tid, last, data});
    endtask

    always @(negedge ACLK) begin
        if (!ARESET && M_TVALID && M_TREADY) begin
            if (exp_q.size() > 0) begin
                check("beat", {M_TID, M_TLAST, M_TDATA}, exp_q.pop_front());
                check("keep", M_TKEEP, 4'hF);
            end else begin
                extra_beats++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic put(input int k, input logic v, input logic [31:0] d, input logic l);
        S_TVALID[k]        = v;
        S_TLAST[k]         = l & v;
        S_TDATA[k*32 +: 32] = d;
        S_TKEEP[k*4 +: 4]  = v ? 4'hF : 4'h0;
        S_TSTRB[k*4 +: 4]  = v ? 4'hF : 4'h0;
        S_TID[k]           = k[0];
        S_TDEST[k]         = k[1];
        S_TUSER[k]         = v;
    endtask

    task automatic idle_all();
        for (int k = 0; k < NS; k++) put(k, 1'b0, 32'h0, 1'b0);
    endtask

    logic [3:0] g_tab [12] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4,
                               4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h2};

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int   bi;
        logic rdy;

        S_TVALID = '0; S_TDATA = '0; S_TSTRB = '0; S_TKEEP = '0;
        S_TLAST  = '0; S_TID   = '0; S_TDEST = '0; S_TUSER = '0;
        M_TREADY = 1'b1;
        ARESET   = 1'b1;
        step();
        step();
        ARESET = 1'b0;
        #1;
        check("rst_grant",  GRANT, 0);
        check("rst_busy",   BUSY, 0);
        check("rst_mvalid", M_TVALID, 0);
        check("rst_tready", S_TREADY, 0);
        check("rst_state",  o_dbg_state, 0);

        // ---- 1: input 2 sends a 3-beat packet ----
        push_exp(1'b0, 1'b0, 32'hA0);
        push_exp(1'b0, 1'b0, 32'hA1);
        push_exp(1'b0, 1'b1, 32'hA2);
        put(2, 1'b1, 32'hA0, 1'b0);
        #1;
        check("t1_idle_grant",  GRANT, 0);
        check("t1_idle_mvalid", M_TVALID, 0);
        check("t1_idle_tready", S_TREADY, 0);
        step();
        #1;
        check("t1_grant",  GRANT, 4'b0100);
        check("t1_busy",   BUSY, 1);
        check("t1_mvalid", M_TVALID, 1);
        check("t1_data",   M_TDATA, 32'hA0);
        check("t1_tready", S_TREADY, 4'b0100);
        step();
        put(2, 1'b1, 32'hA1, 1'b0);
        step();
        put(2, 1'b1, 32'hA2, 1'b1);
        #1;
        check("t1_busy_last", BUSY, 1);
        step();
        put(2, 1'b0, 32'h0, 1'b0);
        #1;
        check("t1_busy_end",  BUSY, 0);
        check("t1_grant_end", GRANT, 0);

        // ---- 2: all inputs stream 1-beat packets from reset ----
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        for (int k = 0; k < NS; k++) put(k, 1'b1, 32'hB0 + 32'(k), 1'b1);
        push_exp(1'b0, 1'b1, 32'hB0);
        push_exp(1'b1, 1'b1, 32'hB1);
        push_exp(1'b0, 1'b1, 32'hB2);
        push_exp(1'b1, 1'b1, 32'hB3);
        push_exp(1'b0, 1'b1, 32'hB0);
        push_exp(1'b1, 1'b1, 32'hB1);
        for (int i = 0; i < 12; i++) begin
            #1;
            check("t2_grant", GRANT, g_tab[i]);
            check("t2_busy",  BUSY, (g_tab[i] != 4'h0));
            step();
        end
        idle_all();
        #1;
        check("t2_grant_end", GRANT, 0);
        step();

        // ---- 3: input 1 holds grant across a TVALID gap ----
        push_exp(1'b1, 1'b0, 32'hC0);
        push_exp(1'b1, 1'b1, 32'hC1);
        push_exp(1'b0, 1'b1, 32'hD0);
        put(1, 1'b1, 32'hC0, 1'b0);
        step();
        put(0, 1'b1, 32'hD0, 1'b1);
        #1;
        check("t3_grant",  GRANT, 4'b0010);
        check("t3_tready", S_TREADY, 4'b0010);
        step();
        put(1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t3_gap_grant",  GRANT, 4'b0010);
            check("t3_gap_mvalid", M_TVALID, 0);
            check("t3_gap_tready", S_TREADY, 4'b0010);
            step();
        end
        put(1, 1'b1, 32'hC1, 1'b1);
        #1;
        check("t3_grant_last", GRANT, 4'b0010);
        check("t3_data_last",  M_TDATA, 32'hC1);
        step();
        put(1, 1'b0, 32'h0, 1'b0);
        #1;
        check("t3_dead", GRANT, 0);
        step();
        #1;
        check("t3_grant0", GRANT, 4'b0001);
        check("t3_data0",  M_TDATA, 32'hD0);
        step();
        put(0, 1'b0, 32'h0, 1'b0);
        #1;
        check("t3_end", GRANT, 0);
        step();

        // ---- 4: M_TREADY toggles during a 4-beat packet from input 3 ----
        for (int i = 0; i < 4; i++) push_exp(1'b1, (i == 3), 32'hE0 + 32'(i));
        put(3, 1'b1, 32'hE0, 1'b0);
        step();
        bi = 0;
        for (int c = 1; c < 20 && bi < 4; c++) begin
            rdy = c[0];
            M_TREADY = rdy;
            put(3, 1'b1, 32'hE0 + 32'(bi), (bi == 3));
            #1;
            check("t4_tready", S_TREADY, {rdy, 3'b000});
            check("t4_data",   M_TDATA, 32'hE0 + 32'(bi));
            step();
            if (rdy) bi++;
        end
        M_TREADY = 1'b1;
        put(3, 1'b0, 32'h0, 1'b0);
        #1;
        check("t4_end", GRANT, 0);
        step();

        // ---- 5: reset mid-packet from input 1 ----
        push_exp(1'b1, 1'b0, 32'hF0);
        push_exp(1'b1, 1'b0, 32'hF1);
        push_exp(1'b0, 1'b1, 32'h60);
        put(1, 1'b1, 32'hF0, 1'b0);
        step();
        #1;
        check("t5_grant", GRANT, 4'b0010);
        step();
        put(1, 1'b1, 32'hF1, 1'b0);
        step();
        put(1, 1'b1, 32'hF2, 1'b0);
        M_TREADY = 1'b0;
        ARESET   = 1'b1;
        step();
        ARESET   = 1'b0;
        M_TREADY = 1'b1;
        #1;
        check("t5_rst_grant",  GRANT, 0);
        check("t5_rst_busy",   BUSY, 0);
        check("t5_rst_mvalid", M_TVALID, 0);
        check("t5_rst_state",  o_dbg_state, 0);
        put(0, 1'b1, 32'h60, 1'b1);
        step();
        #1;
        check("t5_grant0", GRANT, 4'b0001);
        check("t5_data0",  M_TDATA, 32'h60);
        step();
        put(0, 1'b0, 32'h0, 1'b0);
        put(1, 1'b0, 32'h0, 1'b0);
        #1;
        check("t5_dead", GRANT, 0);
        step();
        #1;
        check("t5_drop", GRANT, 0);

        // ---- 6: last=3, inputs 1 and 3 request -> 1 then 3 ----
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        push_exp(1'b1, 1'b1, 32'h71);
        push_exp(1'b1, 1'b1, 32'h73);
        put(1, 1'b1, 32'h71, 1'b1);
        put(3, 1'b1, 32'h73, 1'b1);
        #1;
        check("t6_idle", GRANT, 0);
        step();
        #1;
        check("t6_grant1", GRANT, 4'b0010);
        step();
        put(1, 1'b0, 32'h0, 1'b0);
        #1;
        check("t6_dead", GRANT, 0);
        step();
        #1;
        check("t6_grant3", GRANT, 4'b1000);
        check("t6_data3",  M_TDATA, 32'h73);
        step();
        put(3, 1'b0, 32'h0, 1'b0);
        #1;
        check("t6_end", GRANT, 0);
        step();
        step();

        // ---- final report ----
        check("extra_beats",   extra_beats, 0);
        check("missing_beats", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
